keypad_emulator: RTL

// Synthesizable model of a 4x4 matrix keypad: the passive end of the row-scan/column-sense interface.

---
 rtl/keypad_emulator.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Purpose: passive 4x4 matrix keypad model; pulls the commanded key's column low while its row is driven.
// Latency: rows->columns is combinational; a command takes effect the cycle after it is accepted.
// Backpressure: cmd_ready_o is high only in IDLE; cmd_valid_i while busy is ignored, so the source must hold it.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 200000,
  parameter int unsigned BOUNCE_DIV    = 4096,
  parameter int unsigned GAP_CYCLES    = 500000,
  parameter int unsigned HOLD_W        = 24,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        rows_i,
  output logic [3:0]        columns_o,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_row_i,
  input  logic [1:0]        cmd_col_i,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  input  logic              cmd_abort_i,
  output logic              busy_o,
  output logic              contact_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRESS = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // One counter serves every state, so it must be wide enough for the hold field and the 32-bit parameters.
  localparam int unsigned CNT_W = (HOLD_W > 32) ? HOLD_W : 32;

  localparam bit             NO_BOUNCE   = (BOUNCE_CYCLES == 0);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [31:0]      DIV_LOAD    = 32'(BOUNCE_DIV - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       div_q, div_d;
  logic              contact_q, contact_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       lfsr_q, lfsr_d;

  // A hold of zero still gives one solid-contact cycle.
  function automatic logic [CNT_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
    if (h == '0) return '0;
    return CNT_W'(h) - CNT_W'(1);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, free-running in every state.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Press sequencer: every state entry reloads the single down-counter; abort jumps straight to GAP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    contact_d = contact_q;
    row_d     = row_q;
    col_d     = col_q;
    hold_d    = hold_q;
    case (state_q)
      S_IDLE: begin
        contact_d = 1'b0;
        if (cmd_valid_i) begin
          row_d  = cmd_row_i;
          col_d  = cmd_col_i;
          hold_d = cmd_hold_i;
          if (NO_BOUNCE) begin
            state_d   = S_HOLD;
            cnt_d     = hold_load(cmd_hold_i);
            contact_d = 1'b1;
          end else begin
            state_d   = S_PRESS;
            cnt_d     = BOUNCE_LOAD;
            div_d     = DIV_LOAD;
            contact_d = lfsr_q[0];
          end
        end
      end
      S_PRESS, S_REL: begin
        if (cmd_abort_i) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LOAD;
          contact_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (state_q == S_PRESS) begin
            state_d   = S_HOLD;
            cnt_d     = hold_load(hold_q);
            contact_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            cnt_d     = GAP_LOAD;
            contact_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Contact is re-sampled from the LFSR every BOUNCE_DIV cycles within the window.
          if (div_q == '0) begin
            div_d     = DIV_LOAD;
            contact_d = lfsr_q[0];
          end else begin
            div_d = div_q - 32'd1;
          end
        end
      end
      S_HOLD: begin
        if (cmd_abort_i) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LOAD;
          contact_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (NO_BOUNCE) begin
            state_d   = S_GAP;
            cnt_d     = GAP_LOAD;
            contact_d = 1'b0;
          end else begin
            state_d   = S_REL;
            cnt_d     = BOUNCE_LOAD;
            div_d     = DIV_LOAD;
            contact_d = lfsr_q[0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        contact_d = 1'b0;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d   = S_IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops contact so the column lines release without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      contact_q <= 1'b0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      hold_q    <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      contact_q <= contact_d;
      row_q     <= row_d;
      col_q     <= col_d;
      hold_q    <= hold_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Column sense: only the latched row matters; rows[3-r] drives row r, columns[3-c] is column c.
  always_comb begin
    columns_o = 4'b1111;
    if (contact_q && rows_i[2'd3 - row_q]) columns_o[2'd3 - col_q] = 1'b0;
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign contact_o   = contact_q;
  assign done_o      = (state_q == S_GAP) && (cnt_q == '0);

endmodule
